// File: rtl/npc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// the default reset / exception vectors.
package npc_pkg;

    typedef enum logic [2:0] {
        NPC_NONE = 3'd0,
        NPC_BEQ  = 3'd1,
        NPC_BNE  = 3'd2,
        NPC_J    = 3'd3,
        NPC_JR   = 3'd4,
        NPC_ERET = 3'd5
    } npc_sel_e;

    localparam logic [31:0] NPC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VEC   = 32'h0000_4180;

endpackage

// File: rtl/npc_target.sv
// Combinational branch/jump target and taken-flag computation.
// ERET and the reserved codes report not-taken with target = pc_plus4;
// ERET is resolved by the priority logic in the parent.
module npc_target
    import npc_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] i_pc_plus4,
    input  logic [2:0]    i_sel,
    input  logic [25:0]   i_instr_index,
    input  logic [AW-1:0] i_offset,
    input  logic [AW-1:0] i_rs_val,
    input  logic          i_zero,
    output logic [AW-1:0] o_target,
    output logic          o_taken
);

    logic [31:0]   w_pp4_ext;
    logic [31:0]   w_jump;
    logic [AW-1:0] w_branch;

    // The J target is built at 32 bits and truncated, so AW=28 (no region
    // bits above the index) needs no special case.
    assign w_pp4_ext = 32'(i_pc_plus4);
    assign w_jump    = {w_pp4_ext[31:28], i_instr_index, 2'b00};
    assign w_branch  = i_pc_plus4 + (i_offset << 2);

    // Select target and taken flag from the flow type
    always_comb begin
        o_target = i_pc_plus4;
        o_taken  = 1'b0;
        case (i_sel)
            NPC_BEQ: begin
                if (i_zero) begin
                    o_target = w_branch;
                    o_taken  = 1'b1;
                end
            end
            NPC_BNE: begin
                if (!i_zero) begin
                    o_target = w_branch;
                    o_taken  = 1'b1;
                end
            end
            NPC_J: begin
                o_target = w_jump[AW-1:0];
                o_taken  = 1'b1;
            end
            NPC_JR: begin
                o_target = i_rs_val;
                o_taken  = 1'b1;
            end
            default: begin
                o_target = i_pc_plus4;
                o_taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Sequential program-counter unit: PC register, next-PC priority logic,
// exception entry/return with EPC.
// Optional branch-delay-slot sequencing is enabled by defining
// PC_DELAY_SLOT_EN; without it pend and bd are constant 0.
module pc_seq_unit
    import npc_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter logic [31:0] RESET_VEC = NPC_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = NPC_EXC_VEC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_wr,
    input  logic [2:0]    sel,
    input  logic [25:0]   instr_index,
    input  logic [AW-1:0] offset,
    input  logic [AW-1:0] rs_val,
    input  logic          zero,
    input  logic          exc_req,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] npc,
    output logic [AW-1:0] epc,
    output logic          bd,
    output logic          pend
);

    localparam logic [AW-1:0] LP_RST  = RESET_VEC[AW-1:0];
    localparam logic [AW-1:0] LP_EXC  = EXC_VEC[AW-1:0];
    localparam logic [AW-1:0] LP_FOUR = {{(AW-3){1'b0}}, 3'b100};

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_epc;
    logic [AW-1:0] w_pc_plus4;
    logic [AW-1:0] w_target;
    logic          w_taken;
    logic [AW-1:0] w_npc;
    logic          w_pend;
    logic          w_bd;
    logic [AW-1:0] w_pend_tgt;
    logic          w_eret;

    assign w_pc_plus4 = r_pc + LP_FOUR;
    assign w_eret     = (sel == NPC_ERET);

    npc_target #(
        .AW (AW)
    ) u_npc_target (
        .i_pc_plus4    (w_pc_plus4),
        .i_sel         (sel),
        .i_instr_index (instr_index),
        .i_offset      (offset),
        .i_rs_val      (rs_val),
        .i_zero        (zero),
        .o_target      (w_target),
        .o_taken       (w_taken)
    );

`ifdef PC_DELAY_SLOT_EN
    logic [AW-1:0] r_tgt;
    logic          r_pend;
    logic          r_bd;

    // Delay-slot state: hold a taken target for one extra pc_wr, record
    // whether an exception hit the delay-slot instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt  <= '0;
            r_pend <= 1'b0;
            r_bd   <= 1'b0;
        end else if (pc_wr) begin
            if (exc_req) begin
                r_bd   <= r_pend;
                r_pend <= 1'b0;
            end else if (w_eret) begin
                r_bd   <= 1'b0;
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_pend <= 1'b0;
            end else if (w_taken) begin
                r_tgt  <= w_target;
                r_pend <= 1'b1;
            end
        end
    end

    assign w_pend     = r_pend;
    assign w_bd       = r_bd;
    assign w_pend_tgt = r_tgt;
`else
    assign w_pend     = 1'b0;
    assign w_bd       = 1'b0;
    assign w_pend_tgt = '0;
`endif

    // Next-PC priority: exception, ERET, pending target, taken, sequential
    always_comb begin
        w_npc = w_pc_plus4;
        if (exc_req) begin
            w_npc = LP_EXC;
        end else if (w_eret) begin
            w_npc = r_epc;
        end else if (w_pend) begin
            w_npc = w_pend_tgt;
        end else if (w_taken) begin
`ifdef PC_DELAY_SLOT_EN
            w_npc = w_pc_plus4;
`else
            w_npc = w_target;
`endif
        end
    end

    // PC and EPC registers; pc always loads the combinational npc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= LP_RST;
            r_epc <= '0;
        end else if (pc_wr) begin
            r_pc <= w_npc;
            if (exc_req) begin
                r_epc <= w_pend ? (r_pc - LP_FOUR) : r_pc;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign npc      = w_npc;
    assign epc      = r_epc;
    assign bd       = w_bd;
    assign pend     = w_pend;

endmodule
